// File: rtl/uart_rx_input.sv
// uart_rx_input: 8N1 UART receiver with a one-deep, valid/acknowledge output buffer.
//
// Serial bytes on i_uart_rx are synchronised, deframed LSB-first and handed to a slow
// consumer through o_valid/o_data. The consumer pulses i_rd once it has taken the byte.
//
// Ports:
//   i_clk        system clock (16 MHz pin clock)
//   i_reset      synchronous, active-high reset
//   i_uart_rx    asynchronous serial input, idle high
//   i_rd         one-cycle acknowledge from the consumer
//   o_valid      o_data holds an unread byte
//   o_data       last accepted byte (bit0 = first data bit on the line)
//   o_frame_err  sticky: stop bit sampled low
//   o_overrun    sticky: byte completed while o_valid=1 and no i_rd
//   o_busy       receiver FSM is not idle
module uart_rx_input #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd138
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    input  logic       i_rd,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam logic [23:0] HalfM1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
    localparam logic [23:0] FullM1 = CLOCKS_PER_BAUD - 24'd1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        deliver_q, deliver_d;
    logic        ferr_set;
    logic        rx_meta_q, rxs_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        ferr_set  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    // First sample lands mid start bit.
                    cnt_d   = HalfM1;
                end
            end
            StStart: begin
                cnt_d = cnt_q - 24'd1;
                if (cnt_q == '0) begin
                    if (!rxs_q) begin
                        state_d  = StData;
                        bitcnt_d = '0;
                        cnt_d    = FullM1;
                    end else begin
                        state_d = StIdle;  // glitch, not a start bit
                    end
                end
            end
            StData: begin
                cnt_d = cnt_q - 24'd1;
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = FullM1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
            StStop: begin
                cnt_d = cnt_q - 24'd1;
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        deliver_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = StBreak;
                    end
                end
            end
            StBreak: begin
                // A held-low line must return high before another start bit counts.
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output buffer and sticky flags. A set in the same cycle as i_rd wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (deliver_q) begin
                if (!o_valid || i_rd) begin
                    o_data  <= shift_q;
                    o_valid <= 1'b1;
                end
            end else if (i_rd && o_valid) begin
                o_valid <= 1'b0;
            end

            if (ferr_set) begin
                o_frame_err <= 1'b1;
            end else if (i_rd) begin
                o_frame_err <= 1'b0;
            end

            if (deliver_q && o_valid && !i_rd) begin
                o_overrun <= 1'b1;
            end else if (i_rd) begin
                o_overrun <= 1'b0;
            end
        end
    end

    assign o_busy = (state_q != StIdle);

endmodule
